// File: rtl/mips_mdu.sv
// rtl/mips_mdu.sv - MIPS multiply/divide unit owning HI/LO, with MFHI/MFLO read port and stall request
// Define MDU_DIV_EN to build the DIV/DIVU divider; without it DIV/DIVU are accepted as no-ops.
module mips_mdu #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isMDUop,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext, cntLoad;
  logic [31:0]   opA, opB;
  logic [5:0]    opF;
  logic          accept, start, commit;
  logic          isMul, isDiv, isLong;
  logic [63:0]   mulS, mulU;
  logic [31:0]   resHi, resLo;
  logic          resValid;

  assign busy   = (state == RUN);
  assign stall  = isMDUop && busy;
  assign rdata  = (funct == F_MFHI) ? hi : lo;
  assign accept = isMDUop && !busy;

  assign isMul = (funct == F_MULT) || (funct == F_MULTU);
`ifdef MDU_DIV_EN
  assign isDiv = (funct == F_DIV) || (funct == F_DIVU);
`else
  assign isDiv = 1'b0;
`endif
  assign isLong  = isMul || isDiv;
  assign cntLoad = isMul ? CW'(MUL_LAT) : CW'(DIV_LAT);

  // Low 64 bits of a 64x64 product of the extended operands give the 32x32 result.
  assign mulS = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
  assign mulU = {32'b0, opA} * {32'b0, opB};

`ifdef MDU_DIV_EN
  logic [31:0] magA, magB, magQ, magR, sQuo, sRem, uQuo, uRem;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign magA = opA[31] ? -opA : opA;
  assign magB = opB[31] ? -opB : opB;
  assign magQ = magA / magB;
  assign magR = magA % magB;
  assign sQuo = (opA[31] ^ opB[31]) ? -magQ : magQ;
  assign sRem = opA[31] ? -magR : magR;
  assign uQuo = opA / opB;
  assign uRem = opA % opB;
`endif

  always_comb begin
    resHi    = hi;
    resLo    = lo;
    resValid = 1'b0;
    case (opF)
      F_MULT:  begin {resHi, resLo} = mulS; resValid = 1'b1; end
      F_MULTU: begin {resHi, resLo} = mulU; resValid = 1'b1; end
`ifdef MDU_DIV_EN
      F_DIV:   begin resHi = sRem; resLo = sQuo; resValid = (opB != 32'd0); end
      F_DIVU:  begin resHi = uRem; resLo = uQuo; resValid = (opB != 32'd0); end
`endif
      default: resValid = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    start     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && isLong) begin
          stateNext = RUN;
          cntNext   = cntLoad;
          start     = 1'b1;
        end
      end
      RUN: begin
        cntNext = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          stateNext = IDLE;
          commit    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      opA   <= 32'd0;
      opB   <= 32'd0;
      opF   <= 6'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (start) begin
        opA <= a;
        opB <= b;
        opF <= funct;
      end
      // Commit and MT accept are exclusive: accept needs !busy, commit happens only in RUN.
      if (commit && resValid) begin
        hi <= resHi;
        lo <= resLo;
      end else if (accept && funct == F_MTHI) begin
        hi <= a;
      end else if (accept && funct == F_MTLO) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// tb/tb_mips_mdu.sv - self-checking bench for mips_mdu (define MDU_DIV_EN to exercise the divider build)
module tb_mips_mdu;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset;
  logic        isMDUop;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo, rdata;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  mips_mdu #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .isMDUop(isMDUop), .funct(funct), .a(a), .b(b),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rdata(rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: architectural HI/LO, remaining busy cycles and the pending result.
  logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
  bit          pValid = 1'b0;
  int          busyLeft = 0;
  bit          modelOn = 1'b0;
  longint      sProd;
  logic [63:0] uProd;
  int          sa, sb;

  always @(posedge clk) begin
    if (reset) begin
      mHi = 32'd0; mLo = 32'd0; busyLeft = 0; pValid = 1'b0; modelOn = 1'b1;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0 && pValid) begin mHi = pHi; mLo = pLo; end
    end else if (isMDUop) begin
      case (funct)
        F_MULT: begin
          sProd = longint'($signed(a)) * longint'($signed(b));
          {pHi, pLo} = sProd; pValid = 1'b1; busyLeft = MUL_LAT;
        end
        F_MULTU: begin
          uProd = 64'(a) * 64'(b);
          {pHi, pLo} = uProd; pValid = 1'b1; busyLeft = MUL_LAT;
        end
`ifdef MDU_DIV_EN
        F_DIV: begin
          busyLeft = DIV_LAT; pValid = (b != 32'd0);
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin pLo = 32'h8000_0000; pHi = 32'd0; end
          else if (b != 32'd0) begin sa = a; sb = b; pLo = sa / sb; pHi = sa % sb; end
        end
        F_DIVU: begin
          busyLeft = DIV_LAT; pValid = (b != 32'd0);
          if (b != 32'd0) begin pLo = a / b; pHi = a % b; end
        end
`endif
        F_MTHI: mHi = a;
        F_MTLO: mLo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      check("cyc_busy", 32'(busy), 32'(busyLeft > 0));
      check("cyc_stall", 32'(stall), 32'(isMDUop && busyLeft > 0));
      check("cyc_hi", hi, mHi);
      check("cyc_lo", lo, mLo);
      check("cyc_rdata", rdata, (funct == F_MFHI) ? mHi : mLo);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    isMDUop = 1'b1; funct = f; a = x; b = y;
    #1;
  endtask

  task automatic idle;
    isMDUop = 1'b0; funct = 6'd0;
    #1;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  int n;

  initial begin
    reset = 1'b1; isMDUop = 1'b0; funct = 6'd0; a = 32'd0; b = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rdata", rdata, 32'd0);

    present(F_MULT, 32'hFFFF_FFFE, 32'd3); tick(); idle();
    waitIdle(n);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    present(F_MULTU, 32'hFFFF_FFFF, 32'd2); tick();
    present(F_MFLO, 32'h0000_0123, 32'h0000_0456);
    check("mflo_stall", 32'(stall), 32'd1);
    check("mflo_old_lo", rdata, 32'hFFFF_FFFA);
    waitIdle(n);
    check("mflo_unstalled", 32'(stall), 32'd0);
    check("multu_rdata", rdata, 32'hFFFF_FFFE);
    check("multu_hi", hi, 32'h0000_0001);
    tick(); idle();

    present(F_DIV, 32'hFFFF_FFF9, 32'd2); tick(); idle(); waitIdle(n);
`ifdef MDU_DIV_EN
    check("div_busy_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
`else
    check("nodiv_busy_cycles", n, 32'd0);
    check("nodiv_lo", lo, 32'hFFFF_FFFE);
`endif
    present(F_DIVU, 32'd7, 32'd0); tick(); idle(); waitIdle(n);
`ifdef MDU_DIV_EN
    check("div0_busy_cycles", n, 32'd10);
    check("div0_lo", lo, 32'hFFFF_FFFD);
    check("div0_hi", hi, 32'hFFFF_FFFF);
`else
    check("nodiv0_hi", hi, 32'h0000_0001);
`endif
    present(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF); tick(); idle(); waitIdle(n);
    present(F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010); tick(); idle(); waitIdle(n);
`ifdef MDU_DIV_EN
    check("divu_lo", lo, 32'h0FFF_FFFF);
    check("divu_hi", hi, 32'h0000_000F);
`endif
    present(F_DIV, 32'd7, 32'hFFFF_FFFE); tick(); idle(); waitIdle(n);
`ifdef MDU_DIV_EN
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'h0000_0001);
`endif

    present(F_MTHI, 32'h1234_5678, 32'd0); tick();
    present(F_MFHI, 32'd0, 32'd0);
    check("mfhi_rdata", rdata, 32'h1234_5678);
    check("mfhi_stall", 32'(stall), 32'd0);
    check("mthi_busy", 32'(busy), 32'd0);
    present(F_MTLO, 32'hCAFE_F00D, 32'd0); tick();
    present(F_MFLO, 32'd0, 32'd0);
    check("mflo_rdata", rdata, 32'hCAFE_F00D);
    present(6'b000000, 32'hDEAD_BEEF, 32'd1); tick(); idle();
    check("other_funct_hi", hi, 32'h1234_5678);
    check("other_funct_busy", 32'(busy), 32'd0);

    present(F_MULT, 32'd3, 32'd4); tick();
    present(F_MULTU, 32'd5, 32'd6);
    waitIdle(n);
    check("b2b_first_lo", lo, 32'd12);
    tick(); idle();
    check("b2b_second_busy", 32'(busy), 32'd1);
    waitIdle(n);
    check("b2b_second_lo", lo, 32'd30);

    present(F_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB); tick(); idle(); waitIdle(n);
    check("mult_negneg_lo", lo, 32'd15);
    present(F_MULT, 32'h8000_0000, 32'h8000_0000); tick(); idle(); waitIdle(n);
    check("mult_min_hi", hi, 32'h4000_0000);
    present(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick(); idle(); waitIdle(n);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);

`ifdef MDU_DIV_EN
    present(F_DIV, 32'd100, 32'd7);
`else
    present(F_MULT, 32'd100, 32'd7);
`endif
    tick(); idle(); repeat (2) tick();
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (15) tick();
    check("abort_no_commit", lo, 32'd0);

    present(F_DIV, 32'd8, 32'd2); tick(); idle();
`ifdef MDU_DIV_EN
    check("div8_busy", 32'(busy), 32'd1);
    waitIdle(n);
    check("div8_lo", lo, 32'd4);
`else
    check("nodiv8_busy", 32'(busy), 32'd0);
    check("nodiv8_lo", lo, 32'd0);
`endif
    present(F_MULT, 32'd3, 32'd4); tick(); idle(); waitIdle(n);
    check("mult34_cycles", n, 32'd5);
    check("mult34_lo", lo, 32'd12);

    tick();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, got %0d/%0d", passCnt, totalCnt);
    $fatal(1);
  end

endmodule
